// File: rtl/match_chain_pipe.sv
// Ternary key/mask match table with a two-stage lookup pipeline (hit vector, then encode).
// Valid/ready on both sides; table writes are never stalled.
module match_chain_pipe #(
  parameter int KEY_W     = 16,
  parameter int N_ENTRIES = 8,
  localparam int IDX_W    = $clog2(N_ENTRIES),
  localparam int CNT_W    = $clog2(N_ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [KEY_W-1:0] wr_mask,
  input  logic             wr_vld,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [KEY_W-1:0] lk_key,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx,
  output logic [CNT_W-1:0] res_count
);

  logic [KEY_W-1:0]     key_q  [N_ENTRIES];
  logic [KEY_W-1:0]     mask_q [N_ENTRIES];
  logic [N_ENTRIES-1:0] vld_q;

  logic [N_ENTRIES-1:0] hit_vec;
  logic                 s1_valid;
  logic [N_ENTRIES-1:0] s1_hits;
  logic                 s2_adv;
  logic                 enc_hit;
  logic [IDX_W-1:0]     enc_idx;
  logic [CNT_W-1:0]     enc_count;

  // Indices >= N_ENTRIES never equal any loop index, so such writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) vld_q[i] <= wr_vld;
      end
    end
  end

  // NOTE: key/mask storage is deliberately left unreset; vld_q gates every
  // match, so stale contents are never observable and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        key_q[i]  <= wr_key;
        mask_q[i] <= wr_mask;
      end
    end
  end

  // NOTE: combinational blocks assign every output a default first and use
  // blocking '=' so no latch is inferred; clocked blocks use '<=' only.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      hit_vec[i] = vld_q[i] && (((lk_key ^ key_q[i]) & mask_q[i]) == '0);
    end
  end

  // Scanning downward leaves the lowest matching index in enc_idx.
  always_comb begin
    enc_hit   = |s1_hits;
    enc_idx   = '0;
    enc_count = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (s1_hits[i]) begin
        enc_idx   = IDX_W'(i);
        enc_count = enc_count + CNT_W'(1);
      end
    end
  end

  assign s2_adv   = !res_valid || res_ready;
  assign lk_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hits  <= '0;
    end else if (lk_ready) begin
      s1_valid <= lk_valid;
      if (lk_valid) s1_hits <= hit_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_idx   <= '0;
      res_count <= '0;
    end else if (s2_adv) begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_hit   <= enc_hit;
        res_idx   <= enc_idx;
        res_count <= enc_count;
      end
    end
  end

endmodule

// File: tb/tb_match_chain_pipe.sv
// Self-checking bench for match_chain_pipe: table model + result scoreboard,
// with directed scenarios for reset, writes, same-edge hazards, backpressure and mid-flight reset.
module tb_match_chain_pipe;

  localparam int KEY_W     = 16;
  localparam int N_ENTRIES = 6;
  localparam int IDX_W     = $clog2(N_ENTRIES);
  localparam int CNT_W     = $clog2(N_ENTRIES + 1);

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [KEY_W-1:0] wr_key;
  logic [KEY_W-1:0] wr_mask;
  logic             wr_vld;
  logic             lk_valid;
  logic             lk_ready;
  logic [KEY_W-1:0] lk_key;
  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [IDX_W-1:0] res_idx;
  logic [CNT_W-1:0] res_count;

  int vectors     = 0;
  int miscompares = 0;
  int res_seen    = 0;
  res_t last_res;
  res_t sb_q[$];

  logic [KEY_W-1:0]     m_key  [N_ENTRIES];
  logic [KEY_W-1:0]     m_mask [N_ENTRIES];
  logic [N_ENTRIES-1:0] m_vld;

  match_chain_pipe #(.KEY_W(KEY_W), .N_ENTRIES(N_ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_mask(wr_mask), .wr_vld(wr_vld),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_idx(res_idx), .res_count(res_count)
  );

  always #5 clk = ~clk;

  function automatic res_t model_lookup(input logic [KEY_W-1:0] k);
    res_t r;
    logic found;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (m_vld[i] && (((k ^ m_key[i]) & m_mask[i]) == '0)) begin
        if (!found) r.idx = IDX_W'(i);
        found   = 1'b1;
        r.count = r.count + CNT_W'(1);
      end
    end
    r.hit = found;
    return r;
  endfunction

  // Scoreboard: compare outgoing results, then enqueue accepts against the
  // pre-edge table, then apply this edge's write to the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        res_t e;
        res_t a;
        a = '{hit: res_hit, idx: res_idx, count: res_count};
        vectors++;
        res_seen++;
        last_res = a;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result: got hit=%0b idx=%0d cnt=%0d, expected no result",
                   a.hit, a.idx, a.count);
        end else begin
          e = sb_q.pop_front();
          if (a !== e) begin
            miscompares++;
            $display("FAIL result_order: got hit=%0b idx=%0d cnt=%0d, expected hit=%0b idx=%0d cnt=%0d",
                     a.hit, a.idx, a.count, e.hit, e.idx, e.count);
          end
        end
      end
      if (lk_valid && lk_ready) sb_q.push_back(model_lookup(lk_key));
      if (wr_en && (int'(wr_idx) < N_ENTRIES)) begin
        m_key[wr_idx]  = wr_key;
        m_mask[wr_idx] = wr_mask;
        m_vld[wr_idx]  = wr_vld;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input logic [KEY_W-1:0] k,
                             input logic [KEY_W-1:0] m, input logic v);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_key = k; wr_mask = m; wr_vld = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic stream(input logic [KEY_W-1:0] keys[$]);
    lk_valid = 1'b1;
    foreach (keys[n]) begin
      int budget;
      lk_key = keys[n];
      budget = 0;
      @(negedge clk);
      while (!lk_ready && budget < 50) begin
        budget++;
        @(negedge clk);
      end
      if (!lk_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: lk_ready=%0b after %0d cycles, expected 1", lk_ready, budget);
      end
      @(posedge clk);
      #1;
    end
    lk_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((sb_q.size() != 0 || res_valid) && budget < 40) begin
      budget++;
      @(posedge clk);
      #2;
    end
    vectors++;
    if (sb_q.size() != 0 || res_valid) begin
      miscompares++;
      $display("FAIL drain: %0d results pending res_valid=%0b, expected 0 pending", sb_q.size(), res_valid);
    end
  endtask

  task automatic check_last(input string name, input res_t exp);
    vectors++;
    if (last_res !== exp) begin
      miscompares++;
      $display("FAIL %s: got hit=%0b idx=%0d cnt=%0d, expected hit=%0b idx=%0d cnt=%0d",
               name, last_res.hit, last_res.idx, last_res.count, exp.hit, exp.idx, exp.count);
    end
  endtask

  task automatic test_reset();
    int budget;
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_mask = '0; wr_vld = 1'b0;
    lk_valid = 1'b0; lk_key = '0; res_ready = 1'b1;
    m_vld = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({res_valid, res_hit, res_idx, res_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b hit=%0b idx=%0d cnt=%0d, expected all 0",
               res_valid, res_hit, res_idx, res_count);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (lk_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_lk_ready: got %0b, expected 1", lk_ready);
    end
    lk_valid = 1'b1; lk_key = 16'h0000;
    @(negedge clk);
    step();
    lk_valid = 1'b0;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: res_valid=%0b right after accept, expected 0", res_valid);
    end
    budget = 0;
    while (!res_valid && budget < 2) begin
      budget++;
      step();
    end
    vectors++;
    if (res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: res_valid=%0b two edges after accept, expected 1", res_valid);
    end
    wait_drain();
    check_last("reset_lookup", '{hit: 1'b0, idx: '0, count: '0});
  endtask

  task automatic test_match();
    write_entry(3, 16'h1234, 16'hFFFF, 1'b1);
    write_entry(5, 16'h1200, 16'hFF00, 1'b1);
    stream('{16'h1234});
    wait_drain();
    check_last("two_hits", '{hit: 1'b1, idx: IDX_W'(3), count: CNT_W'(2)});
    stream('{16'h12AA});
    wait_drain();
    check_last("masked_hit", '{hit: 1'b1, idx: IDX_W'(5), count: CNT_W'(1)});
  endtask

  task automatic test_same_edge_write();
    wr_en = 1'b1; wr_idx = '0; wr_key = 16'hAAAA; wr_mask = 16'hFFFF; wr_vld = 1'b1;
    lk_valid = 1'b1; lk_key = 16'hAAAA;
    @(negedge clk);
    vectors++;
    if (lk_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL same_edge_ready: got %0b, expected 1", lk_ready);
    end
    step();
    wr_en = 1'b0; lk_valid = 1'b0;
    wait_drain();
    check_last("same_edge_miss", '{hit: 1'b0, idx: '0, count: '0});
    stream('{16'hAAAA});
    wait_drain();
    check_last("after_write_hit", '{hit: 1'b1, idx: '0, count: CNT_W'(1)});
  endtask

  task automatic test_back_to_back();
    int seen0 = res_seen;
    fork
      stream('{16'h1234, 16'h12AA, 16'hAAAA, 16'h0000, 16'h1200, 16'hFFFF});
      begin
        res_t snap;
        int budget = 0;
        @(negedge clk);
        while (!res_valid && budget < 20) begin
          budget++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        snap = '{hit: res_hit, idx: res_idx, count: res_count};
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          vectors++;
          if (!res_valid || ({res_hit, res_idx, res_count} !== snap)) begin
            miscompares++;
            $display("FAIL stall_hold: cycle %0d valid=%0b hit=%0b idx=%0d cnt=%0d, expected frozen hit=%0b idx=%0d cnt=%0d",
                     c, res_valid, res_hit, res_idx, res_count, snap.hit, snap.idx, snap.count);
          end
        end
        vectors++;
        if (lk_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_lk_ready: got %0b with both stages full, expected 0", lk_ready);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    wait_drain();
    vectors++;
    if (res_seen - seen0 != 6) begin
      miscompares++;
      $display("FAIL stream_count: got %0d results, expected 6", res_seen - seen0);
    end
  endtask

  task automatic test_out_of_range();
    write_entry(N_ENTRIES, 16'h1234, 16'hFFFF, 1'b1);
    write_entry(3, 16'h1234, 16'hFFFF, 1'b0);
    stream('{16'h1234});
    wait_drain();
    check_last("invalidated", '{hit: 1'b1, idx: IDX_W'(5), count: CNT_W'(1)});
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0;
    stream('{16'h1234, 16'hAAAA});
    #2;
    rst = 1'b1;
    sb_q.delete();
    m_vld = '0;
    #1;
    vectors++;
    if ({res_valid, res_hit, res_idx, res_count} !== '0 || lk_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%0b hit=%0b idx=%0d cnt=%0d ready=%0b, expected 0/0/0/0/1",
               res_valid, res_hit, res_idx, res_count, lk_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_valid: cycle %0d res_valid=%0b, expected 0", c, res_valid);
      end
    end
    stream('{16'h1234});
    wait_drain();
    check_last("post_reset_miss", '{hit: 1'b0, idx: '0, count: '0});
  endtask

  initial begin
    test_reset();
    test_match();
    test_same_edge_write();
    test_back_to_back();
    test_out_of_range();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
